itcm_fetch_rsp: RTL
===================

# itcm_fetch_rsp

Instruction-memory responder serving the fetch unit's `pc_o`/`inst_i` pair. It holds a word-organised instruction SRAM and returns the addressed instruction one cycle after the PC is presented. The response register is hold-aware. A byte-strobed load port lets the boot/debug master write program words, and writes are arbitrated against fetch.

## Interface
Parameters:
- DEPTH, 4096: instruction words in the array; power of two.
- RESET_NOP, 32'h0000_0013: value driven on `inst_o` after reset and on out-of-range fetch (`addi x0,x0,0`).

Ports:
- clk  in  1  core clock; single clock domain.
- rst  in  1  reset, asynchronous, active-high.
- pc_i  in  `INST_ADDR_WIDTH` (32)  fetch address from the PC stage; byte address, bits [1:0] ignored.
- fetch_hold_i  in  1  pipeline hold; response register frozen while high.
- inst_o  out  `INST_DATA_WIDTH` (32)  registered instruction to IF/ID.
- inst_valid_o  out  1  `inst_o` carries data for the PC sampled on the previous edge.
- fetch_oor_o  out  1  previous fetch address was beyond DEPTH.
- ld_valid_i  in  1  load request.
- ld_ready_o  out  1  load port can accept.
- ld_addr_i  in  32  load byte address, word aligned.
- ld_data_i  in  32  load data.
- ld_strb_i  in  4  byte enables.
- ld_err_o  out  1  one-cycle pulse: load address out of range and discarded.
- parity_err_o  out  1  parity mismatch on the word now on `inst_o`.

## Operation
- Word index is `pc_i[2 +: log2(DEPTH)]`. A fetch is out of range when `pc_i[31:2] >= DEPTH`.
- Load FSM, IDLE/WR:
  - `ld_ready_o = (state==IDLE)`.
  - IDLE → WR on `ld_valid_i & ld_ready_o`. Address, data and strobes are captured at that edge.
  - WR → IDLE unconditionally. The array write (strobed bytes only) happens at the edge that ends WR.
  - Maximum load rate is one word per 2 cycles.
- Arbitration: the load has priority. In WR the fetch read is not performed. At the WR-ending edge `inst_o` keeps its value and `inst_valid_o` goes 0, unless `fetch_hold_i` is high, in which case both are held.
- Out-of-range load: accepted, FSM still enters WR, no array write, `ld_err_o`=1 during the WR cycle.
- Out-of-range fetch: `inst_o`←RESET_NOP, `inst_valid_o`←1, `fetch_oor_o`←1.
- `fetch_hold_i` high at an edge: `inst_o`, `inst_valid_o`, `fetch_oor_o` and `parity_err_o` all retain their values. The load FSM continues.
- Array contents are not reset.

## Timing
- Reset values: `inst_o`=RESET_NOP, `inst_valid_o`=0, `fetch_oor_o`=0, `ld_err_o`=0, `parity_err_o`=0, state=IDLE (so `ld_ready_o`=1).
- Fetch latency is 1: `pc_i` sampled at edge N gives `inst_o` and `inst_valid_o`=1 after edge N (no hold, state IDLE).
- Read-after-write: a word written at the WR-ending edge M is returned by a fetch sampled at edge M+1 or later.
- Same-cycle load acceptance and fetch in IDLE: the fetch completes normally. The following cycle is WR, so the next fetch is dropped.
- `rst` asserted during WR aborts the write: the array is unchanged and all outputs take their reset values immediately.
- `ld_err_o` is high only in the WR cycle of a discarded load.

## Configuration
- Macro `ITCM_PARITY_EN`.
- Defined:
  - The array stores 4 extra even-parity bits, one per byte.
  - A load writes the parity of each strobed byte only.
  - A fetch recomputes parity. On any mismatch, `parity_err_o`=1 in the same cycle as the affected `inst_o`, while `inst_o` still carries the raw word.
  - Out-of-range fetches never flag parity.
  - Words never loaded may flag, so the boot flow must preload the whole used range.
- Undefined: no parity storage, `parity_err_o` tied 0, port list unchanged.

## Test plan
- Reset, then load 0x0000_0093 to addr 0x10 with strb=4'hF. Fetch pc 0x10 → next cycle `inst_o`=0x0000_0093, `inst_valid_o`=1.
- Back-to-back `ld_valid_i` held high for 3 words → `ld_ready_o` toggles 1,0,1,0,1. All three words read back correctly.
- Load 0xAABB_CCDD with strb=4'b0101 over a word of 0x1122_3344 → fetch returns 0x11BB_33DD.
- Fetch pc = DEPTH*4 → `inst_o`=0x0000_0013, `fetch_oor_o`=1. Load to the same address → `ld_err_o` pulse, array unchanged.
- Assert `fetch_hold_i` for 3 cycles while pc changes and a load completes → `inst_o` constant throughout. After hold drops, the cycle following WR shows `inst_valid_o`=0.
- With `ITCM_PARITY_EN`, force-flip one array bit at addr 0x20 and fetch it → `parity_err_o`=1 with the corrupted word. Assert `rst` mid-WR → word not written, `inst_o`=RESET_NOP.

Source files
------------

// File: rtl/itcm_fetch_rsp.sv
// -----------------------------------------------------------------------------
// itcm_fetch_rsp
//
// Instruction-memory responder for the fetch unit. A word-organised instruction
// array returns the word addressed by pc_i one cycle after it is presented.
// The response register is hold-aware. A byte-strobed load port (boot/debug
// master) writes program words and has priority over fetch: while the load
// FSM is in WR, the fetch read is skipped.
//
// Optional feature macro: ITCM_PARITY_EN
//   defined   : each byte lane stores an extra even-parity bit. A fetch
//               recomputes it and flags parity_err_o alongside the raw word.
//   undefined : no parity storage, parity_err_o is tied low.
//
// Parameters
//   DEPTH      instruction words in the array (power of two)
//   RESET_NOP  word driven on inst_o after reset and for out-of-range fetch
//
// Ports
//   clk           core clock
//   rst           asynchronous active-high reset
//   pc_i          fetch byte address (bits [1:0] ignored)
//   fetch_hold_i  freezes inst_o / inst_valid_o / fetch_oor_o / parity_err_o
//   inst_o        registered instruction
//   inst_valid_o  inst_o holds data for the PC sampled on the previous edge
//   fetch_oor_o   previous fetch address was beyond DEPTH
//   ld_valid_i    load request
//   ld_ready_o    load port can accept (FSM idle)
//   ld_addr_i     load byte address, word aligned
//   ld_data_i     load data
//   ld_strb_i     load byte enables
//   ld_err_o      high during the WR cycle of a discarded (out-of-range) load
//   parity_err_o  parity mismatch on the word now on inst_o
// -----------------------------------------------------------------------------
module itcm_fetch_rsp #(
    parameter int          DEPTH     = 4096,
    parameter logic [31:0] RESET_NOP = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc_i,
    input  logic        fetch_hold_i,
    output logic [31:0] inst_o,
    output logic        inst_valid_o,
    output logic        fetch_oor_o,
    input  logic        ld_valid_i,
    output logic        ld_ready_o,
    input  logic [31:0] ld_addr_i,
    input  logic [31:0] ld_data_i,
    input  logic [3:0]  ld_strb_i,
    output logic        ld_err_o,
    output logic        parity_err_o
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

`ifdef ITCM_PARITY_EN
    localparam int LANE_W = 9;   // bit 8 = even parity of the byte
`else
    localparam int LANE_W = 8;
`endif

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_WR   = 1'b1;

    // ---------------------------------------------------------------------
    // Address decode
    // ---------------------------------------------------------------------
    logic [AW-1:0] rd_idx;
    logic          rd_oor;
    logic [AW-1:0] ld_idx;
    logic          ld_oor;
    logic          unused_addr_bits;

    assign rd_idx = pc_i[2 +: AW];
    assign rd_oor = (pc_i[31:2] >= 30'(DEPTH));
    assign ld_idx = ld_addr_i[2 +: AW];
    assign ld_oor = (ld_addr_i[31:2] >= 30'(DEPTH));

    // Byte-offset bits carry no information for word accesses.
    assign unused_addr_bits = ^{pc_i[1:0], ld_addr_i[1:0]};

    // ---------------------------------------------------------------------
    // Load FSM: IDLE accepts, WR performs the array write at its ending edge.
    // ---------------------------------------------------------------------
    logic [0:0]    state_reg, state_next;
    logic [AW-1:0] ld_idx_reg;
    logic [31:0]   ld_data_reg;
    logic [3:0]    ld_strb_reg;
    logic          ld_oor_reg;
    logic          ld_accept;
    logic          wr_en;

    assign ld_ready_o = (state_reg == ST_IDLE);
    assign ld_accept  = ld_ready_o & ld_valid_i;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: if (ld_valid_i) state_next = ST_WR;
            ST_WR:   state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= ST_IDLE;
            ld_idx_reg  <= '0;
            ld_data_reg <= '0;
            ld_strb_reg <= '0;
            ld_oor_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (ld_accept) begin
                ld_idx_reg  <= ld_idx;
                ld_data_reg <= ld_data_i;
                ld_strb_reg <= ld_strb_i;
                ld_oor_reg  <= ld_oor;
            end
        end
    end

    // A reset during WR drops state_reg to IDLE immediately, so the
    // following edge sees wr_en low and the pending write is abandoned.
    assign wr_en    = (state_reg == ST_WR) & ~ld_oor_reg;
    assign ld_err_o = (state_reg == ST_WR) & ld_oor_reg;

    // ---------------------------------------------------------------------
    // Storage: one array per byte lane so each strobe is an independent
    // write enable. Contents are never reset.
    // ---------------------------------------------------------------------
    logic [31:0] rd_word;
    logic        rd_perr;
`ifdef ITCM_PARITY_EN
    logic [3:0]  lane_perr;
`endif

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            logic [LANE_W-1:0] lane_mem [DEPTH];
            logic [LANE_W-1:0] lane_wr;
            logic [LANE_W-1:0] lane_rd;

`ifdef ITCM_PARITY_EN
            assign lane_wr = {^ld_data_reg[8*gi +: 8], ld_data_reg[8*gi +: 8]};
`else
            assign lane_wr = ld_data_reg[8*gi +: 8];
`endif

            always_ff @(posedge clk) begin
                if (wr_en && ld_strb_reg[gi]) begin
                    lane_mem[ld_idx_reg] <= lane_wr;
                end
            end

            // Read data is captured by the response register below.
            assign lane_rd            = lane_mem[rd_idx];
            assign rd_word[8*gi +: 8] = lane_rd[7:0];
`ifdef ITCM_PARITY_EN
            // Stored parity plus data bits must XOR to zero.
            assign lane_perr[gi] = ^lane_rd;
`endif
        end
    endgenerate

`ifdef ITCM_PARITY_EN
    assign rd_perr = |lane_perr;
`else
    assign rd_perr = 1'b0;
`endif

    // ---------------------------------------------------------------------
    // Response register
    // ---------------------------------------------------------------------
    logic [31:0] inst_reg;
    logic        inst_valid_reg;
    logic        fetch_oor_reg;
    logic        parity_err_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inst_reg       <= RESET_NOP;
            inst_valid_reg <= 1'b0;
            fetch_oor_reg  <= 1'b0;
            parity_err_reg <= 1'b0;
        end else if (!fetch_hold_i) begin
            if (state_reg == ST_WR) begin
                // Fetch read slot is taken by the load; keep the old word
                // but mark it stale.
                inst_valid_reg <= 1'b0;
            end else if (rd_oor) begin
                inst_reg       <= RESET_NOP;
                inst_valid_reg <= 1'b1;
                fetch_oor_reg  <= 1'b1;
                parity_err_reg <= 1'b0;
            end else begin
                inst_reg       <= rd_word;
                inst_valid_reg <= 1'b1;
                fetch_oor_reg  <= 1'b0;
                parity_err_reg <= rd_perr;
            end
        end
    end

    assign inst_o       = inst_reg;
    assign inst_valid_o = inst_valid_reg;
    assign fetch_oor_o  = fetch_oor_reg;
    assign parity_err_o = parity_err_reg;

endmodule
